// File: rtl/bch_dec_pipe_univ_top_pkg.sv
// Shared constants and constant functions for the DEC BCH decoder.
// Code is the shortened systematic binary BCH code with t=2 over GF(2^m).
package bch_dec_pipe_univ_top_pkg;

    // Smallest field degree m whose code length 2^m-1 holds data plus 2m checks.
    function automatic int fn_gf_m(input int dw);
        int m;
        m = 8;
        for (int k = 8; k >= 4; k--) begin
            if ((1 << k) - 1 >= dw + 2 * k) m = k;
        end
        return m;
    endfunction

    // ECC width equals syndrome width (two m-bit syndromes S1, S3).
    function automatic int fn_ecc_synd_width(input int dw);
        return 2 * fn_gf_m(dw);
    endfunction

    // Generator polynomial g(x) = m1(x) * m3(x) for the double-error BCH code.
    function automatic logic [16:0] fn_gen_poly(input int m);
        logic [16:0] g;
        unique case (m)
            4:       g = 17'o721;
            5:       g = 17'o3551;
            7:       g = 17'o41567;
            8:       g = 17'o267543;
            default: g = 17'o12471;
        endcase
        return g;
    endfunction

    // Parity column of data bit i: x^(SW+i) mod g(x).
    function automatic logic [15:0] fn_col(input int dw, input int i);
        logic [16:0] r;
        logic [16:0] g;
        int          sw;
        sw = fn_ecc_synd_width(dw);
        g  = fn_gen_poly(fn_gf_m(dw));
        r  = 17'd1;
        for (int k = 0; k < sw + i; k++) begin
            r = r << 1;
            if (r[sw]) r = r ^ g;
        end
        return r[15:0];
    endfunction

    // All-ones saturation value of a w-bit statistics counter.
    function automatic logic [63:0] fn_cnt_sat(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/bch_dec_err_cnt.sv
// Saturating error-statistics counter; clear beats increment.
// Only built when BCH_DEC_ERR_CNT_EN is defined.
`ifdef BCH_DEC_ERR_CNT_EN
module bch_dec_err_cnt
    import bch_dec_pipe_univ_top_pkg::*;
#(
    parameter int P_W = 16
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           inc_i,
    input  logic           clr_i,
    output logic [P_W-1:0] cnt_o
);

    localparam logic [P_W-1:0] SAT = P_W'(fn_cnt_sat(P_W));

    logic [P_W-1:0] cnt_q;
    logic [P_W-1:0] cnt_d;

    // Next count: clear first, otherwise step until all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && cnt_q != SAT) begin
            cnt_d = cnt_q + P_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/enc_synd_calc_univ.sv
// Systematic BCH parity encoder / syndrome generator.
// P_SYND_GEN=0 yields ECC bits; P_SYND_GEN=1 folds in the received ECC.
module enc_synd_calc_univ
    import bch_dec_pipe_univ_top_pkg::*;
#(
    parameter  int P_D_WIDTH  = 32,
    parameter  int P_SYND_GEN = 0,
    localparam int SW         = fn_ecc_synd_width(P_D_WIDTH)
) (
    input  logic [P_D_WIDTH-1:0] d_i,
    input  logic [SW-1:0]        ecc_i,
    output logic [SW-1:0]        syn_o
);

    logic [SW-1:0] term [P_D_WIDTH];

    for (genvar i = 0; i < P_D_WIDTH; i++) begin : g_col
        localparam logic [SW-1:0] C = SW'(fn_col(P_D_WIDTH, i));
        assign term[i] = d_i[i] ? C : '0;
    end

    // XOR the columns of all set data bits, plus received ECC when checking.
    always_comb begin
        syn_o = (P_SYND_GEN != 0) ? ecc_i : '0;
        for (int i = 0; i < P_D_WIDTH; i++) begin
            syn_o = syn_o ^ term[i];
        end
    end

endmodule

// File: rtl/err_pat_dcd_rom_univ.sv
// Syndrome to data error-mask decoder for up to two bit errors.
// ECC-field errors are recognised but never touch the data mask.
module err_pat_dcd_rom_univ
    import bch_dec_pipe_univ_top_pkg::*;
#(
    parameter  int P_D_WIDTH = 32,
    localparam int SW        = fn_ecc_synd_width(P_D_WIDTH)
) (
    input  logic [SW-1:0]        syn_i,
    output logic [P_D_WIDTH-1:0] msk_o
);

    logic [SW-1:0] col [P_D_WIDTH];

    for (genvar i = 0; i < P_D_WIDTH; i++) begin : g_col
        localparam logic [SW-1:0] C = SW'(fn_col(P_D_WIDTH, i));
        assign col[i] = C;
    end

    // Flag bit i if the syndrome is its column alone or paired with any other column.
    always_comb begin
        msk_o = '0;
        for (int i = 0; i < P_D_WIDTH; i++) begin
            if (syn_i == col[i]) msk_o[i] = 1'b1;
            for (int j = 0; j < P_D_WIDTH; j++) begin
                if (j != i && syn_i == (col[i] ^ col[j])) msk_o[i] = 1'b1;
            end
            for (int k = 0; k < SW; k++) begin
                if (syn_i == (col[i] ^ (SW'(1) << k))) msk_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bch_dec_pipe_univ_top.sv
// Two-stage flow-controlled DEC BCH decoder with optional error counters.
// Counters are present only when BCH_DEC_ERR_CNT_EN is defined.
module bch_dec_pipe_univ_top
    import bch_dec_pipe_univ_top_pkg::*;
#(
    parameter  int P_D_WIDTH   = 32,
    parameter  int P_CNT_WIDTH = 16,
    localparam int SW          = fn_ecc_synd_width(P_D_WIDTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   vld_i,
    output logic                   rdy_o,
    input  logic [P_D_WIDTH-1:0]   d_i,
    input  logic [SW-1:0]          ecc_i,
    output logic                   vld_o,
    input  logic                   rdy_i,
    output logic [P_D_WIDTH-1:0]   d_o,
    output logic                   err_det_o,
    output logic                   err_dat_o,
    input  logic                   clr_cnt_i,
    output logic [P_CNT_WIDTH-1:0] cnt_det_o,
    output logic [P_CNT_WIDTH-1:0] cnt_dat_o
);

    logic                 s1_vld_q;
    logic [P_D_WIDTH-1:0] s1_d_q;
    logic [SW-1:0]        s1_syn_q;
    logic                 vld_q;
    logic [P_D_WIDTH-1:0] d_q;
    logic                 det_q;
    logic                 dat_q;
    logic [SW-1:0]        syn;
    logic [P_D_WIDTH-1:0] msk;
    logic                 s1_en;
    logic                 s2_en;

    assign s2_en = ~vld_q | rdy_i;
    assign s1_en = ~s1_vld_q | s2_en;
    assign rdy_o = s1_en;

    enc_synd_calc_univ #(
        .P_D_WIDTH (P_D_WIDTH),
        .P_SYND_GEN(1)
    ) u_syn (
        .d_i  (d_i),
        .ecc_i(ecc_i),
        .syn_o(syn)
    );

    err_pat_dcd_rom_univ #(
        .P_D_WIDTH(P_D_WIDTH)
    ) u_rom (
        .syn_i(s1_syn_q),
        .msk_o(msk)
    );

    // Stage 1: capture the word and its syndrome whenever the slot frees.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_vld_q <= 1'b0;
            s1_d_q   <= '0;
            s1_syn_q <= '0;
        end else if (s1_en) begin
            s1_vld_q <= vld_i;
            s1_d_q   <= d_i;
            s1_syn_q <= syn;
        end
    end

    // Stage 2: apply the correction mask and register the flags.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            vld_q <= 1'b0;
            d_q   <= '0;
            det_q <= 1'b0;
            dat_q <= 1'b0;
        end else if (s2_en) begin
            vld_q <= s1_vld_q;
            d_q   <= s1_d_q ^ msk;
            det_q <= |s1_syn_q;
            dat_q <= |msk;
        end
    end

    assign vld_o     = vld_q;
    assign d_o       = d_q;
    assign err_det_o = det_q;
    assign err_dat_o = dat_q;

`ifdef BCH_DEC_ERR_CNT_EN
    logic xfer_o;
    assign xfer_o = vld_q & rdy_i;

    bch_dec_err_cnt #(
        .P_W(P_CNT_WIDTH)
    ) u_cnt_det (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .inc_i  (xfer_o & det_q),
        .clr_i  (clr_cnt_i),
        .cnt_o  (cnt_det_o)
    );

    bch_dec_err_cnt #(
        .P_W(P_CNT_WIDTH)
    ) u_cnt_dat (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .inc_i  (xfer_o & dat_q),
        .clr_i  (clr_cnt_i),
        .cnt_o  (cnt_dat_o)
    );
`else
    logic unused_clr;
    assign unused_clr = clr_cnt_i;
    assign cnt_det_o  = {P_CNT_WIDTH{1'b0}};
    assign cnt_dat_o  = {P_CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_bch_dec_pipe_univ_top.sv
// Bench for bch_dec_pipe_univ_top: scoreboard of clean words plus directed cases.
// Counter expectations follow BCH_DEC_ERR_CNT_EN when it is defined.
module tb_bch_dec_pipe_univ_top;

    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [31:0] d;
        logic        det;
        logic        dat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          vld_i = 1'b0;
    logic          rdy_o;
    logic [31:0]   d_i = '0;
    logic [11:0]   ecc_i = '0;
    logic          vld_o;
    logic          rdy_i = 1'b1;
    logic [31:0]   d_o;
    logic          err_det_o;
    logic          err_dat_o;
    logic          clr_cnt_i = 1'b0;
    logic [CW-1:0] cnt_det_o;
    logic [CW-1:0] cnt_dat_o;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t cur;
    int   occ = 0;
    int   cm_det = 0;
    int   cm_dat = 0;

    bch_dec_pipe_univ_top #(
        .P_D_WIDTH  (32),
        .P_CNT_WIDTH(CW)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n_i),
        .vld_i    (vld_i),
        .rdy_o    (rdy_o),
        .d_i      (d_i),
        .ecc_i    (ecc_i),
        .vld_o    (vld_o),
        .rdy_i    (rdy_i),
        .d_o      (d_o),
        .err_det_o(err_det_o),
        .err_dat_o(err_dat_o),
        .clr_cnt_i(clr_cnt_i),
        .cnt_det_o(cnt_det_o),
        .cnt_dat_o(cnt_dat_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ECC as the remainder of d(x)*x^12 divided by g(x)=x^12+x^10+x^8+x^5+x^4+x^3+1.
    function automatic logic [11:0] m_ecc(input logic [31:0] d);
        logic [43:0] r;
        r = {d, 12'h000};
        for (int b = 43; b >= 12; b--) begin
            if (r[b]) r = r ^ (44'(13'h1539) << (b - 12));
        end
        return r[11:0];
    endfunction

    // Scoreboard: check handshake, ordering, hold and counters on every cycle.
    logic        hv = 1'b0;
    logic [31:0] hd;
    logic        hdet;
    logic        hdat;
    always @(negedge clk) begin
        exp_t e;
        int   ced;
        int   cea;
        if (!rst_n_i) begin
            exp_q.delete();
            occ    = 0;
            cm_det = 0;
            cm_dat = 0;
            hv     = 1'b0;
        end else begin
`ifdef BCH_DEC_ERR_CNT_EN
            ced = cm_det;
            cea = cm_dat;
`else
            ced = 0;
            cea = 0;
`endif
            chk("rdy_o", 32'(rdy_o), 32'(!(occ == 2 && !rdy_i)));
            chk("cnt_det", 32'(cnt_det_o), ced);
            chk("cnt_dat", 32'(cnt_dat_o), cea);
            if (hv) begin
                chk("hold_vld", 32'(vld_o), 1);
                chk("hold_d", d_o, hd);
                chk("hold_det", 32'(err_det_o), 32'(hdet));
                chk("hold_dat", 32'(err_dat_o), 32'(hdat));
            end
            if (vld_o && rdy_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious: got word %h expected none", d_o);
                end else begin
                    e = exp_q.pop_front();
                    occ--;
                    chk("out_d", d_o, e.d);
                    chk("out_det", 32'(err_det_o), 32'(e.det));
                    chk("out_dat", 32'(err_dat_o), 32'(e.dat));
                    if (!clr_cnt_i) begin
                        if (e.det && cm_det < CMAX) cm_det++;
                        if (e.dat && cm_dat < CMAX) cm_dat++;
                    end
                end
            end
            if (clr_cnt_i) begin
                cm_det = 0;
                cm_dat = 0;
            end
            if (vld_i && rdy_o) begin
                exp_q.push_back(cur);
                occ++;
            end
            hv   = vld_o && !rdy_i;
            hd   = d_o;
            hdet = err_det_o;
            hdat = err_dat_o;
        end
    end

    task automatic send(input logic [31:0] d, input logic [31:0] df, input logic [11:0] ef);
        logic acc;
        cur.d   = d;
        cur.det = (df != 0) || (ef != 0);
        cur.dat = (df != 0);
        vld_i   = 1'b1;
        d_i     = d ^ df;
        ecc_i   = m_ecc(d) ^ ef;
        acc     = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = rdy_o;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept: got no rdy_o expected acceptance of %h", d);
        end
    endtask

    task automatic idle();
        vld_i = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && occ != 0; k++) @(negedge clk);
        chk("drain_occ", occ, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic one(input string nm, input logic [31:0] d, input logic [31:0] df,
                       input logic [11:0] ef, input logic [31:0] xd,
                       input logic xdet, input logic xdat);
        send(d, df, ef);
        idle();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (vld_o) break;
        end
        chk({nm, "_vld"}, 32'(vld_o), 1);
        chk({nm, "_d"}, d_o, xd);
        chk({nm, "_det"}, 32'(err_det_o), 32'(xdet));
        chk({nm, "_dat"}, 32'(err_dat_o), 32'(xdat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1);
    end

    initial begin
        int exp_cnt;
        chk("model_ecc_x12", 32'(m_ecc(32'h1)), 32'h539);
        chk("model_ecc_x13", 32'(m_ecc(32'h2)), 32'hA72);
        chk("model_ecc_lin", 32'(m_ecc(32'h3)), 32'hF4B);

        repeat (2) @(posedge clk);
        #1;
        rst_n_i = 1'b1;
        @(negedge clk);
        chk("rst_vld", 32'(vld_o), 0);
        chk("rst_d", d_o, 0);
        chk("rst_det", 32'(err_det_o), 0);
        chk("rst_dat", 32'(err_dat_o), 0);
        chk("rst_rdy", 32'(rdy_o), 1);
        @(posedge clk);
        #1;

        // Test 1: clean word, two-cycle latency
        send(32'hDEADBEEF, 0, 0);
        idle();
        @(negedge clk);
        chk("t1_early", 32'(vld_o), 0);
        @(negedge clk);
        chk("t1_vld", 32'(vld_o), 1);
        chk("t1_d", d_o, 32'hDEADBEEF);
        chk("t1_det", 32'(err_det_o), 0);
        chk("t1_dat", 32'(err_dat_o), 0);
        @(posedge clk);
        #1;

        // Tests 2/3: single, double and ECC-only errors
        one("t2_b5", 32'hDEADBEEF, 32'h0000_0020, 12'h000, 32'hDEADBEEF, 1, 1);
        one("t2_b0_31", 32'hDEADBEEF, 32'h8000_0001, 12'h000, 32'hDEADBEEF, 1, 1);
        one("t3_ecc0", 32'h0, 32'h0, 12'h001, 32'h0, 1, 0);
        one("t3_ecc2", 32'h1234_5678, 32'h0, 12'h801, 32'h1234_5678, 1, 0);
        one("t3_mix", 32'hA5A5_0F0F, 32'h0000_0080, 12'h800, 32'hA5A5_0F0F, 1, 1);

        // Test 4: back-to-back stream with sink stalled for three cycles
        fork
            begin
                for (int w = 1; w <= 4; w++) send(32'(w), 0, 0);
                idle();
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                rdy_i = 1'b0;
                @(negedge clk);
                chk("t4_rdy_low", 32'(rdy_o), 0);
                chk("t4_head", d_o, 32'h1);
                repeat (3) @(posedge clk);
                #1;
                rdy_i = 1'b1;
            end
        join
        drain();

        // Test 5: reset with both stages full
        rdy_i = 1'b0;
        send(32'h0BAD_0001, 32'h4, 0);
        send(32'h0BAD_0002, 32'h8, 0);
        idle();
        @(negedge clk);
        chk("t5_pre_vld", 32'(vld_o), 1);
        chk("t5_pre_rdy", 32'(rdy_o), 0);
        @(posedge clk);
        #1;
        rst_n_i = 1'b0;
        vld_i   = 1'b1;
        d_i     = 32'h0BAD_0003;
        ecc_i   = m_ecc(32'h0BAD_0003);
        @(posedge clk);
        #1;
        rst_n_i = 1'b1;
        vld_i   = 1'b0;
        rdy_i   = 1'b1;
        @(negedge clk);
        chk("t5_vld", 32'(vld_o), 0);
        chk("t5_d", d_o, 0);
        chk("t5_cdet", 32'(cnt_det_o), 0);
        chk("t5_cdat", 32'(cnt_dat_o), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_no_stale", 32'(vld_o), 0);
        end
        @(posedge clk);
        #1;

        // Test 6: saturation and clear priority
        for (int k = 0; k < 5; k++) send(32'h1000_0000 + 32'(k), 32'h1 << (3 * k), 0);
        idle();
        drain();
`ifdef BCH_DEC_ERR_CNT_EN
        exp_cnt = 3;
`else
        exp_cnt = 0;
`endif
        @(negedge clk);
        chk("t6_sat_dat", 32'(cnt_dat_o), exp_cnt);
        chk("t6_sat_det", 32'(cnt_det_o), exp_cnt);
        @(posedge clk);
        #1;
        send(32'hCAFE_0000, 32'h10, 0);
        idle();
        @(posedge clk);
        #1;
        clr_cnt_i = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt_i = 1'b0;
        @(negedge clk);
        chk("t6_clr_det", 32'(cnt_det_o), 0);
        chk("t6_clr_dat", 32'(cnt_dat_o), 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
